// File: rtl/bus_capture_fifo.sv
// bus_capture_fifo: samples the gated data bus on bus_en and queues bytes for a consumer
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   bus_in, bus_en     bus byte and its enable; a byte is captured every enabled cycle
//   rd_en              pop request; dout/dout_valid are registered one edge later
//   clr_ovf            clears the sticky overflow flag
//   dout, dout_valid   popped byte and its one-cycle valid strobe
//   empty, full, count fill status decoded from the registered count
//   overflow           sticky: a byte was dropped while full
module bus_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           bus_in,
  input  logic                       bus_en,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr_ok, rd_ok, ovf_set;
  assign empty = count == '0;
  assign full = count == FULL_CNT;
  // a pop in the same cycle frees a slot, so a write while full still lands
  assign wr_ok = bus_en & (~full | rd_en);
  assign rd_ok = rd_en & ~empty;
  assign ovf_set = bus_en & full & ~rd_en;
  always_ff @(posedge clk)
    if (wr_ok) mem[wp] <= bus_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) begin
        dout <= mem[rp];
        rp <= rp + 1'b1;
      end
      dout_valid <= rd_ok;
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      overflow <= ovf_set | (overflow & ~clr_ovf);
    end
endmodule
